// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - access-size encodings, store entry type and byte-span helper for store_buffer
package store_buffer_pkg;

   typedef enum logic [2:0] {
      SZ_B  = 3'b000,
      SZ_H  = 3'b001,
      SZ_W  = 3'b010,
      SZ_BU = 3'b100,
      SZ_HU = 3'b101
   } size_ctr_e;

   localparam int SB_DATA_WIDTH = 32;
   localparam int SB_ADDR_WIDTH = 12;

   typedef struct packed {
      logic [SB_ADDR_WIDTH-1:0] addr;
      logic [1:0]               size;
      logic [SB_DATA_WIDTH-1:0] data;
   } sb_entry_t;

   function automatic logic [2:0] span_bytes(input logic [1:0] size);
      case (size)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/sb_overlap.sv
// rtl/sb_overlap.sv - byte-span intersection of one load against one buffered store
module sb_overlap
   import store_buffer_pkg::*;
#(
   parameter int ADDR_WIDTH = 12
)(
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [1:0]            load_size,
   input  logic [ADDR_WIDTH-1:0] entry_addr,
   input  logic [1:0]            entry_size,
   input  logic                  entry_valid,
   output logic                  hit
);

   // one extra bit so spans ending at the top of the address space never wrap
   logic [ADDR_WIDTH:0] load_end;
   logic [ADDR_WIDTH:0] entry_end;

   assign load_end  = {1'b0, load_addr} + (ADDR_WIDTH+1)'(span_bytes(load_size));
   assign entry_end = {1'b0, entry_addr} + (ADDR_WIDTH+1)'(span_bytes(entry_size));

   assign hit = entry_valid
             && ({1'b0, load_addr} < entry_end)
             && ({1'b0, entry_addr} < load_end);

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - pending-store FIFO in front of data memory; STORE_BUFFER_FWD_EN enables load forwarding
module store_buffer
   import store_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = SB_DATA_WIDTH,
   parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
   parameter int DEPTH      = 4
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  MemWrite,
   input  logic                  MemRead,
   input  logic [2:0]            SizeCtr,
   input  logic [ADDR_WIDTH-1:0] ALUResult,
   input  logic [DATA_WIDTH-1:0] WriteData,
   output logic                  Stall,
   output logic                  Empty,
   output logic                  MemWriteOut,
   output logic [2:0]            SizeCtrOut,
   output logic [ADDR_WIDTH-1:0] AddrOut,
   output logic [DATA_WIDTH-1:0] WriteDataOut,
   input  logic [DATA_WIDTH-1:0] MemReadData,
   output logic [DATA_WIDTH-1:0] ReadData
);

   localparam int PW = $clog2(DEPTH);

   sb_entry_t        entries [DEPTH];
   logic [PW-1:0]    head, tail;
   logic [PW:0]      count;
   logic [DEPTH-1:0] valid, hit;
   logic             is_load, conflict, fwd, full, enq, pop;

   // an entry is live when its age behind head is below the occupancy
   always_comb begin
      valid = '0;
      for (int i = 0; i < DEPTH; i++)
         valid[i] = ({1'b0, PW'(i) - head}) < count;
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_ovl
      sb_overlap #(.ADDR_WIDTH(ADDR_WIDTH)) u_ovl (
         .load_addr  (ALUResult),
         .load_size  (SizeCtr[1:0]),
         .entry_addr (entries[g].addr),
         .entry_size (entries[g].size),
         .entry_valid(valid[g]),
         .hit        (hit[g])
      );
   end

   assign is_load  = MemRead && !MemWrite;
   assign conflict = is_load && (|hit);
   assign full     = count == (PW+1)'(DEPTH);
   assign enq      = MemWrite && !full;
   assign pop      = (count != '0) && !(is_load && !conflict);
   assign Stall    = (MemWrite && full) || (conflict && !fwd);
   assign Empty    = count == '0;

`ifdef STORE_BUFFER_FWD_EN
   logic [PW-1:0]         young;
   logic [DATA_WIDTH-1:0] yd, fwd_data;

   // later ages overwrite earlier ones, leaving the youngest overlapping store
   always_comb begin
      young = head;
      for (int k = 0; k < DEPTH; k++)
         if (hit[head + PW'(k)]) young = head + PW'(k);
   end

   assign yd  = entries[young].data;
   assign fwd = conflict && (entries[young].addr == ALUResult)
                         && (entries[young].size == SizeCtr[1:0]);

   always_comb begin
      case (SizeCtr)
         SZ_B:    fwd_data = {{(DATA_WIDTH-8){yd[7]}}, yd[7:0]};
         SZ_H:    fwd_data = {{(DATA_WIDTH-16){yd[15]}}, yd[15:0]};
         SZ_BU:   fwd_data = {{(DATA_WIDTH-8){1'b0}}, yd[7:0]};
         SZ_HU:   fwd_data = {{(DATA_WIDTH-16){1'b0}}, yd[15:0]};
         default: fwd_data = yd;
      endcase
   end

   assign ReadData = fwd ? fwd_data : MemReadData;
`else
   assign fwd      = 1'b0;
   assign ReadData = MemReadData;
`endif

   always_comb begin
      MemWriteOut  = 1'b0;
      SizeCtrOut   = SizeCtr;
      AddrOut      = ALUResult;
      WriteDataOut = entries[head].data;
      if (pop) begin
         MemWriteOut = 1'b1;
         SizeCtrOut  = {1'b0, entries[head].size};
         AddrOut     = entries[head].addr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) tail <= tail + 1'b1;
         if (pop) head <= head + 1'b1;
         case ({enq, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (enq) entries[tail] <= '{addr: ALUResult, size: SizeCtr[1:0], data: WriteData};
   end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - randomized self-checking bench for store_buffer against a queue/byte-array model
module tb_store_buffer;
   localparam int DW    = 32;
   localparam int AW    = 12;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          MemWrite, MemRead;
   logic [2:0]    SizeCtr;
   logic [AW-1:0] ALUResult;
   logic [DW-1:0] WriteData;
   logic          Stall, Empty, MemWriteOut;
   logic [2:0]    SizeCtrOut;
   logic [AW-1:0] AddrOut;
   logic [DW-1:0] WriteDataOut, MemReadData, ReadData;

   logic [7:0]    mem     [0:4095];
   logic [7:0]    ref_mem [0:4095];
   logic [AW-1:0] qa [$];
   logic [1:0]    qs [$];
   logic [DW-1:0] qd [$];
   logic [AW-1:0] drained [$];
   int            checks = 0;
   int            errors = 0;
   int            stall_cycles;
   logic [DW-1:0] last_rd;

   store_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .MemWrite(MemWrite), .MemRead(MemRead),
      .SizeCtr(SizeCtr), .ALUResult(ALUResult), .WriteData(WriteData),
      .Stall(Stall), .Empty(Empty), .MemWriteOut(MemWriteOut),
      .SizeCtrOut(SizeCtrOut), .AddrOut(AddrOut), .WriteDataOut(WriteDataOut),
      .MemReadData(MemReadData), .ReadData(ReadData)
   );

   always #5 clk = ~clk;

   function automatic int nbytes(input logic [1:0] s);
      return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [DW-1:0] extend(input logic [31:0] w, input logic [2:0] sz);
      case (sz)
         3'b000:  return {{24{w[7]}}, w[7:0]};
         3'b001:  return {{16{w[15]}}, w[15:0]};
         3'b100:  return {24'h0, w[7:0]};
         3'b101:  return {16'h0, w[15:0]};
         default: return w;
      endcase
   endfunction

   function automatic logic [DW-1:0] ref_read(input int a, input logic [2:0] sz);
      return extend({ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]}, sz);
   endfunction

   always_comb MemReadData = extend({mem[AddrOut + 12'd3], mem[AddrOut + 12'd2],
                                     mem[AddrOut + 12'd1], mem[AddrOut]}, SizeCtrOut);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      bit ld, conf, fwd, popx;
      int n, yi, a, sz0;
      ld   = MemRead && !MemWrite;
      a    = int'(ALUResult);
      n    = nbytes(SizeCtr[1:0]);
      sz0  = qa.size();
      conf = 0;
      yi   = -1;
      if (ld)
         foreach (qa[i])
            if (a < int'(qa[i]) + nbytes(qs[i]) && int'(qa[i]) < a + n) begin
               conf = 1;
               yi   = i;
            end
      fwd = 0;
`ifdef STORE_BUFFER_FWD_EN
      if (conf && qa[yi] == ALUResult && qs[yi] == SizeCtr[1:0]) fwd = 1;
`endif
      chk("empty", Empty, sz0 == 0);
      chk("stall", Stall, (MemWrite && sz0 == DEPTH) || (conf && !fwd));
      popx = 0;
      if (ld && !conf) begin
         chk("ld_we", MemWriteOut, 0);
         chk("ld_addr", AddrOut, ALUResult);
         chk("ld_size", SizeCtrOut, SizeCtr);
         chk("ld_data", ReadData, ref_read(a, SizeCtr));
      end else if (sz0 > 0) begin
         chk("drain_we", MemWriteOut, 1);
         chk("drain_addr", AddrOut, qa[0]);
         chk("drain_size", SizeCtrOut, {1'b0, qs[0]});
         chk("drain_data", WriteDataOut, qd[0]);
         popx = 1;
      end else begin
         chk("idle_we", MemWriteOut, 0);
      end
      if (fwd) chk("fwd_data", ReadData, extend(qd[yi], SizeCtr));
      if (popx) begin
         for (int j = 0; j < nbytes(qs[0]); j++) ref_mem[int'(qa[0]) + j] = qd[0][8*j +: 8];
         void'(qa.pop_front());
         void'(qs.pop_front());
         void'(qd.pop_front());
      end
      if (MemWrite && sz0 < DEPTH) begin
         qa.push_back(ALUResult);
         qs.push_back(SizeCtr[1:0]);
         qd.push_back(WriteData);
      end
   endtask

   // caller is just after a rising edge; the request is held while Stall is up
   task automatic issue(input logic w, input logic r, input logic [2:0] sz,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      MemWrite = w; MemRead = r; SizeCtr = sz; ALUResult = a; WriteData = d;
      stall_cycles = 0;
      @(negedge clk);
      while (Stall && stall_cycles < 20) begin
         stall_cycles++;
         @(negedge clk);
      end
      chk("stall_bound", Stall, 0);
      last_rd = ReadData;
      @(posedge clk);
      #1;
      MemWrite = 0;
      MemRead  = 0;
   endtask

   initial begin
      logic [2:0] ldsz [5];
      ldsz = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      MemWrite = 0; MemRead = 0; SizeCtr = 0; ALUResult = 0; WriteData = 0; rst_n = 0;
      for (int i = 0; i < 4096; i++) begin
         mem[i]     = 8'h00;
         ref_mem[i] = 8'h00;
      end
      fork
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               chk("rst_empty", Empty, 1);
               chk("rst_we", MemWriteOut, 0);
               chk("rst_stall", Stall, 0);
               qa.delete(); qs.delete(); qd.delete();
            end else begin
               model_step();
            end
            if (MemWriteOut) begin
               drained.push_back(AddrOut);
               for (int j = 0; j < nbytes(SizeCtrOut[1:0]); j++)
                  mem[int'(AddrOut) + j] = WriteDataOut[8*j +: 8];
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      chk("reset_empty", Empty, 1);
      chk("reset_stall", Stall, 0);
      rst_n = 1;

      issue(1, 0, 3'b010, 12'h100, 32'hDEADBEEF);
      @(negedge clk);
      chk("sw_drain_we", MemWriteOut, 1);
      chk("sw_drain_addr", AddrOut, 12'h100);
      chk("sw_drain_data", WriteDataOut, 32'hDEADBEEF);
      @(posedge clk);
      #1;
      chk("sw_empty_after", Empty, 1);
      issue(0, 1, 3'b010, 12'h100, 0);
      chk("lw_back", last_rd, 32'hDEADBEEF);

      issue(1, 0, 3'b001, 12'h102, 32'h1234ABCD);
      issue(0, 1, 3'b100, 12'h103, 0);
      chk("lbu_stall_cycles", stall_cycles, 1);
      chk("lbu_data", last_rd, 32'h000000AB);

      issue(1, 0, 3'b010, 12'h200, 32'h000000F0);
      issue(0, 1, 3'b000, 12'h200, 0);
`ifdef STORE_BUFFER_FWD_EN
      chk("lb_fwd_stall_cycles", stall_cycles, 0);
`else
      chk("lb_stall_cycles", stall_cycles, 1);
`endif
      chk("lb_data", last_rd, 32'hFFFFFFF0);

      drained.delete();
      for (int k = 0; k < 5; k++) begin
         issue(1, 0, 3'b010, 12'h300 + 12'(4*k), 32'hA0000000 + k);
         issue(0, 1, 3'b010, 12'h800, 0);
      end
      for (int k = 0; k < 8; k++) issue(1, 0, 3'b010, 12'h400 + 12'(4*k), 32'hB0000000 + k);
      repeat (3) issue(0, 0, 3'b000, 12'h000, 0);
      chk("order_len", drained.size(), 13);
      for (int k = 0; k < 13; k++)
         if (k < drained.size())
            chk("order_addr", drained[k], (k < 5) ? 12'h300 + 12'(4*k) : 12'h400 + 12'(4*(k-5)));

      drained.delete();
      for (int k = 0; k < 3; k++) issue(1, 0, 3'b010, 12'h500 + 12'(4*k), 32'h11223344 + k);
      #2 rst_n = 0;
      #1 chk("midrst_empty", Empty, 1);
      @(negedge clk);
      #1 rst_n = 1;
      repeat (3) begin
         @(negedge clk);
         chk("midrst_no_write", MemWriteOut, 0);
      end
      chk("midrst_drained", drained.size(), 2);
      chk("midrst_mem", mem[12'h508], 8'h00);
      @(posedge clk);
      #1;

      for (int it = 0; it < 300; it++) begin
         int op, n;
         logic [2:0] sz;
         logic [AW-1:0] a;
         op = $urandom_range(0, 3);
         sz = (op == 2) ? ldsz[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
         n  = nbytes(sz[1:0]);
         a  = 12'h100 + 12'($urandom_range(0, 31) & ~(n - 1));
         if ($urandom_range(0, 9) == 0) a = 12'h800;
         issue(op == 1 || op == 3, op >= 2, sz, a, $urandom);
      end
      repeat (3) issue(0, 0, 3'b000, 12'h000, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
